dff_input_debounce: RTL and testbench

//   Input conditioner that sits directly upstream of edge_dff on its d pin.

---
 rtl/dff_input_debounce.sv | 166 ++++++++++++++++
 tb/tb_dff_input_debounce.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dff_input_debounce.sv
// ============================================================================
// Module      : dff_input_debounce
// Description : Synchroniser and debouncer for an asynchronous level, with
//               one-cycle rise/fall strobes and a saturating glitch counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_input_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                d_raw,
  output logic                q,
  output logic                qbar,
  output logic                rise,
  output logic                fall,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [CNT_W-1:0]    c_CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]    c_CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] c_GLITCH_MAX = '1;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_sync;

  always_ff @(posedge clk) begin
    if (clear) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_raw};
    end
  end

  assign d_sync = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Qualification FSM
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                q_q, q_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                busy_q, busy_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                glitch_inc;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;

    case (state_q)
      ST_LOW: begin
        q_d = 1'b0;
        if (d_sync) begin
          state_d = ST_CHK_HIGH;
          cnt_d   = c_CNT_ONE;
        end
      end

      ST_CHK_HIGH: begin
        if (!d_sync) begin
          state_d    = ST_LOW;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == c_CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          q_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end

      ST_HIGH: begin
        q_d = 1'b1;
        if (!d_sync) begin
          state_d = ST_CHK_LOW;
          cnt_d   = c_CNT_ONE;
        end
      end

      ST_CHK_LOW: begin
        if (d_sync) begin
          state_d    = ST_HIGH;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == c_CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          q_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end

      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
        q_d     = 1'b0;
      end
    endcase

    // busy is registered, so it follows the state being entered
    busy_d = (state_d == ST_CHK_HIGH) || (state_d == ST_CHK_LOW);

    glitch_d = glitch_q;
    if (glitch_inc && (glitch_q != c_GLITCH_MAX)) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      q_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  assign q          = q_q;
  assign qbar       = ~q_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;

endmodule

`default_nettype wire

// File: tb/tb_dff_input_debounce.sv
// ============================================================================
// Module      : tb_dff_input_debounce
// Description : Directed bench; strobe events are checked by a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dff_input_debounce;

  logic       clk = 1'b0;
  logic       clear;
  logic       d_raw;
  logic       q, qbar, rise, fall, busy;
  logic [7:0] glitch_cnt;

  dff_input_debounce #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .GLITCH_W     (8)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .d_raw     (d_raw),
    .q         (q),
    .qbar      (qbar),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic is_rise;
    int   edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_cnt);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic expect_strobe(input logic is_rise, input int edge_no);
    exp_t e;
    e.is_rise = is_rise;
    e.edge_no = edge_no;
    exp_q.push_back(e);
  endtask

  // Monitor: invariants every cycle, strobes popped against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    check("qbar_complement", {31'd0, qbar}, {31'd0, ~q});
    check("rise_fall_exclusive", {31'd0, rise & fall}, 32'd0);
    if (rise === 1'b1 || fall === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe_rise", {31'd0, rise}, 32'd0);
        check("unexpected_strobe_fall", {31'd0, fall}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind_rise", {31'd0, rise}, {31'd0, e.is_rise});
        check("strobe_edge", edge_cnt, e.edge_no);
      end
    end
  end

  initial begin
    int  base;
    logic q_dropped;

    // 1) reset
    clear = 1'b1;
    d_raw = 1'b0;
    wait_edges(2);
    check("rst_q", {31'd0, q}, 32'd0);
    check("rst_qbar", {31'd0, qbar}, 32'd1);
    check("rst_rise", {31'd0, rise}, 32'd0);
    check("rst_fall", {31'd0, fall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_glitch", {24'd0, glitch_cnt}, 32'd0);
    clear = 1'b0;
    wait_edges(2);

    // 2) clean rise
    d_raw = 1'b1;
    base  = edge_cnt;
    expect_strobe(1'b1, base + 6);
    wait_edges(2);
    check("t2_busy_e2", {31'd0, busy}, 32'd0);
    wait_edges(1);
    check("t2_busy_e3", {31'd0, busy}, 32'd1);
    check("t2_q_e3", {31'd0, q}, 32'd0);
    wait_edges(3);
    check("t2_q_e6", {31'd0, q}, 32'd1);
    check("t2_rise_e6", {31'd0, rise}, 32'd1);
    check("t2_busy_e6", {31'd0, busy}, 32'd0);
    wait_edges(1);
    check("t2_rise_e7", {31'd0, rise}, 32'd0);
    wait_edges(2);

    // 3) clean fall
    d_raw = 1'b0;
    base  = edge_cnt;
    expect_strobe(1'b0, base + 6);
    for (int i = 1; i <= 5; i++) begin
      wait_edges(1);
      check("t3_q_held", {31'd0, q}, 32'd1);
    end
    wait_edges(1);
    check("t3_q_e6", {31'd0, q}, 32'd0);
    check("t3_fall_e6", {31'd0, fall}, 32'd1);
    wait_edges(2);

    // 4) two-clock high glitch
    d_raw = 1'b1;
    wait_edges(2);
    d_raw = 1'b0;
    wait_edges(6);
    check("t4_q", {31'd0, q}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_glitch", {24'd0, glitch_cnt}, 32'd1);

    // 5) settle high, then toggle until the glitch counter saturates
    d_raw = 1'b1;
    base  = edge_cnt;
    expect_strobe(1'b1, base + 6);
    wait_edges(8);
    check("t5_q_start", {31'd0, q}, 32'd1);
    q_dropped = 1'b0;
    for (int i = 0; i < 600; i++) begin
      d_raw = ~d_raw;
      wait_edges(1);
      if (q !== 1'b1) q_dropped = 1'b1;
    end
    wait_edges(4);
    check("t5_q_never_dropped", {31'd0, q_dropped}, 32'd0);
    check("t5_q_end", {31'd0, q}, 32'd1);
    check("t5_glitch_sat", {24'd0, glitch_cnt}, 32'd255);

    // 6) clear during qualification
    d_raw = 1'b0;
    base  = edge_cnt;
    expect_strobe(1'b0, base + 6);
    wait_edges(8);
    check("t6_q_low", {31'd0, q}, 32'd0);
    d_raw = 1'b1;
    wait_edges(3);
    check("t6_busy_before_clear", {31'd0, busy}, 32'd1);
    clear = 1'b1;
    wait_edges(1);
    clear = 1'b0;
    base  = edge_cnt;
    check("t6_q_after_clear", {31'd0, q}, 32'd0);
    check("t6_busy_after_clear", {31'd0, busy}, 32'd0);
    check("t6_glitch_after_clear", {24'd0, glitch_cnt}, 32'd0);
    expect_strobe(1'b1, base + 6);
    wait_edges(2);
    check("t6_no_rise_orig_e6", {31'd0, rise}, 32'd0);
    wait_edges(3);
    check("t6_q_before_rise", {31'd0, q}, 32'd0);
    wait_edges(1);
    check("t6_q_rise", {31'd0, q}, 32'd1);
    check("t6_rise", {31'd0, rise}, 32'd1);
    wait_edges(3);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
